// File: rtl/ram_uart_dumper.sv
// rtl/ram_uart_dumper.sv - reads a RAM image after processor completion and sends it as 8N1 UART frames
//
// Purpose: after the processor's completion pulse, fetches NUM_BYTES bytes starting at
// START_ADDR from the data RAM (one-cycle read latency) and serialises each byte on tx,
// LSB first, with CLKS_PER_BIT clocks per bit.
//
// Optional feature macro: DUMP_CHECKSUM_EN appends one frame carrying the mod-256 sum
// of all dumped bytes, sent immediately after the last image frame.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      completion pulse from the processor, acted on only while idle
//   ram_addr   data RAM read address (holds between reads)
//   ram_r_en   data RAM read enable, high only during the fetch cycle
//   ram_data   RAM read data, valid the cycle after ram_r_en
//   tx         UART serial output, idles high
//   busy       high while a dump is in progress
//   dump_done  one-cycle pulse after the final stop bit

module ram_uart_dumper #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 16,
    parameter int START_ADDR   = 0,
    parameter int NUM_BYTES    = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_r_en,
    input  logic [7:0]        ram_data,
    output logic              tx,
    output logic              busy,
    output logic              dump_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BCNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NUM_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_INIT = ADDR_W'(START_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_START,
        S_DATA,
        S_STOP,
`ifdef DUMP_CHECKSUM_EN
        S_CKSUM,
`endif
        S_FINISH
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_start;
    logic [ADDR_W-1:0]   r_addr;
    logic [BCNT_W-1:0]   r_count;
    logic [CNT_W-1:0]    r_baud;
    logic [3:0]          r_bit;
    logic [7:0]          r_shift;
    logic                w_baud_end;
    logic                w_line_state;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]          r_cksum;
`endif

    assign w_baud_end = (r_baud == BAUD_LAST);

    // The bit-period counter only runs while a frame is on the line.
    always_comb begin
        w_line_state = 1'b0;
        case (r_state)
            S_START, S_DATA, S_STOP: w_line_state = 1'b1;
`ifdef DUMP_CHECKSUM_EN
            S_CKSUM:                 w_line_state = 1'b1;
`endif
            default:                 w_line_state = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        tx           = 1'b1;
        busy         = (r_state != S_IDLE);
        dump_done    = 1'b0;
        ram_r_en     = 1'b0;
        ram_addr     = r_addr;
        case (r_state)
            S_IDLE: begin
                if (r_start) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                ram_r_en     = 1'b1;
                w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_next = S_START;
            end
            S_START: begin
                tx = 1'b0;
                if (w_baud_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                tx = r_shift[0];
                if (w_baud_end && (r_bit == 4'd7)) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    if (r_count == LAST_BYTE) begin
`ifdef DUMP_CHECKSUM_EN
                        w_state_next = S_CKSUM;
`else
                        w_state_next = S_FINISH;
`endif
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            // Whole frame in one state: slot 0 start bit, 1..8 data, 9 stop.
            S_CKSUM: begin
                if (r_bit == 4'd0) begin
                    tx = 1'b0;
                end else if (r_bit == 4'd9) begin
                    tx = 1'b1;
                end else begin
                    tx = r_shift[0];
                end
                if (w_baud_end && (r_bit == 4'd9)) begin
                    w_state_next = S_FINISH;
                end
            end
`endif
            S_FINISH: begin
                dump_done    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: registered start, address/byte counters, bit timing and shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= 1'b0;
            r_addr  <= '0;
            r_count <= '0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_cksum <= '0;
`endif
        end else begin
            r_start <= start;

            if (w_line_state && !w_baud_end) begin
                r_baud <= r_baud + CNT_W'(1);
            end else begin
                r_baud <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_start) begin
                        r_addr  <= ADDR_INIT;
                        r_count <= '0;
`ifdef DUMP_CHECKSUM_EN
                        r_cksum <= '0;
`endif
                    end
                end
                S_CAPTURE: begin
                    r_shift <= ram_data;
                    r_bit   <= '0;
`ifdef DUMP_CHECKSUM_EN
                    r_cksum <= r_cksum + ram_data;
`endif
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 4'd1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        if (r_count != LAST_BYTE) begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_count <= r_count + BCNT_W'(1);
                        end else begin
`ifdef DUMP_CHECKSUM_EN
                            r_shift <= r_cksum;
                            r_bit   <= '0;
`endif
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                S_CKSUM: begin
                    if (w_baud_end) begin
                        r_bit <= r_bit + 4'd1;
                        if (r_bit != 4'd0) begin
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
